// File: rtl/shift_extract_if.sv
// Handshake and data bundle between a controller and the shift_extract field extractor.
interface shift_extract_if;
   logic       start;
   logic [7:0] D;
   logic [1:0] shctrl;
   logic [3:0] Q;
   logic       ovf;
   logic       lost;
   logic       err;
   logic       busy;
   logic       done;

   modport master (output start, D, shctrl, input Q, ovf, lost, err, busy, done);
   modport slave  (input start, D, shctrl, output Q, ovf, lost, err, busy, done);
endinterface

// File: rtl/shift_extract.sv
// Sequential right-shift extractor: undoes a 0/2/4-bit left placement of a 4-bit operand
// one bit per clock and reports the field together with overflow and lost-bit flags.
module shift_extract (
   input  logic           clk,
   input  logic           rst,
   shift_extract_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Shift code to shift count; code 11 has no legal count and is flagged separately.
   function automatic logic [2:0] shift_amount(input logic [1:0] code);
      logic [2:0] amt;
      case (code)
         2'b00:   amt = 3'd0;
         2'b01:   amt = 3'd2;
         2'b10:   amt = 3'd4;
         default: amt = 3'd0;
      endcase
      return amt;
   endfunction

   state_t     state_r, state_s;
   logic [7:0] sreg_r, sreg_s;
   logic [2:0] cnt_r, cnt_s;
   logic       lost_acc_r, lost_acc_s;
   logic [3:0] q_r, q_s;
   logic       ovf_r, ovf_s;
   logic       lost_r, lost_s;
   logic       err_r, err_s;
   logic       busy_r;
   logic       done_r;
   logic [7:0] shifted_s;
   logic [2:0] k_s;

   // Next-state and next-output logic; outputs are computed on entry to DONE so they are
   // valid in the same cycle as the done pulse.
   always_comb begin
      state_s    = state_r;
      sreg_s     = sreg_r;
      cnt_s      = cnt_r;
      lost_acc_s = lost_acc_r;
      q_s        = q_r;
      ovf_s      = ovf_r;
      lost_s     = lost_r;
      err_s      = err_r;
      shifted_s  = {1'b0, sreg_r[7:1]};
      k_s        = shift_amount(bus.shctrl);
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               if (bus.shctrl == 2'b11) begin
                  err_s   = 1'b1;
                  q_s     = 4'd0;
                  ovf_s   = 1'b0;
                  lost_s  = 1'b0;
                  state_s = DONE;
               end else begin
                  sreg_s     = bus.D;
                  cnt_s      = k_s;
                  lost_acc_s = 1'b0;
                  err_s      = 1'b0;
                  if (k_s != 3'd0) begin
                     state_s = SHIFT;
                  end else begin
                     q_s     = bus.D[3:0];
                     ovf_s   = |bus.D[7:4];
                     lost_s  = 1'b0;
                     state_s = DONE;
                  end
               end
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            sreg_s     = shifted_s;
            lost_acc_s = lost_acc_r | sreg_r[0];
            cnt_s      = cnt_r - 3'd1;
            if (cnt_r == 3'd1) begin
               q_s     = shifted_s[3:0];
               ovf_s   = |shifted_s[7:4];
               lost_s  = lost_acc_r | sreg_r[0];
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         sreg_r     <= 8'd0;
         cnt_r      <= 3'd0;
         lost_acc_r <= 1'b0;
         q_r        <= 4'd0;
         ovf_r      <= 1'b0;
         lost_r     <= 1'b0;
         err_r      <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         sreg_r     <= sreg_s;
         cnt_r      <= cnt_s;
         lost_acc_r <= lost_acc_s;
         q_r        <= q_s;
         ovf_r      <= ovf_s;
         lost_r     <= lost_s;
         err_r      <= err_s;
         busy_r     <= (state_s != IDLE);
         done_r     <= (state_s == DONE);
      end
   end

   assign bus.Q    = q_r;
   assign bus.ovf  = ovf_r;
   assign bus.lost = lost_r;
   assign bus.err  = err_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule
